// File: rtl/riscalar_pkg.sv
// Shared fetch-side definitions.
//   XLEN        : architectural register / address width
//   INSTR_BYTES : bytes per instruction word (PC increment)
//   NOP_INSTR   : canonical no-op encoding (addi x0, x0, 0)
//   fetch_tag_t : per-request tag kept while the memory request is in flight
//   fetch_pkt_t : buffered instruction/PC pair handed to decode
package riscalar_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            epoch;
    } fetch_tag_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_fifo_sync.sv
// Synchronous FIFO with flush, used for both the in-flight tag queue and the
// instruction buffer of the fetch unit.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push/i_data: write one entry (ignored when full or flushing)
//   i_pop        : drop the head entry (ignored when empty)
//   i_flush      : empty the FIFO next cycle; wins over push and pop
//   o_data       : head entry, forced to zero while empty
//   o_full, o_empty, o_count : occupancy status
module fifo_sync #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd];

    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: o_data is masked while empty.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: holds the fetch PC, issues word requests to
// instruction memory, buffers in-order responses and hands {instruction, pc}
// pairs to decode. Redirects flush wrong-path state.
//   clk_in, rst_in                    : clock, asynchronous active-high reset
//   redirect_valid_in, redirect_pc_in : one-cycle PC change from execute
//   imem_req_valid_out/ready_in/addr  : memory request channel
//   imem_resp_valid_in/data_in        : in-order responses, no backpressure
//   instr_valid_out/ready_in          : decode handshake
//   instruction_out, pc_out           : buffered pair presented to decode
module fetch_unit
    import riscalar_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        redirect_valid_in,
    input  logic [31:0] redirect_pc_in,
    output logic        imem_req_valid_out,
    input  logic        imem_req_ready_in,
    output logic [31:0] imem_addr_out,
    input  logic        imem_resp_valid_in,
    input  logic [31:0] imem_resp_data_in,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic            r_epoch;
    logic [CW-1:0]   r_credits;
    logic [CW-1:0]   r_stale;

    logic            w_req_fire;
    logic            w_flush;
    logic            w_tag_pop;
    logic            w_resp_keep;
    logic            w_resp_drop;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;
    fetch_tag_t      w_tag_in;
    fetch_tag_t      w_tag_out;
    fetch_pkt_t      w_pkt_in;
    fetch_pkt_t      w_pkt_out;
    logic            w_tag_full;
    logic            w_tag_empty;
    logic [CW-1:0]   w_tag_count;
    logic            w_buf_full;
    logic            w_buf_empty;
    logic [CW-1:0]   w_buf_count;
    logic [CW-1:0]   w_credits_next;
    logic [CW-1:0]   w_stale_next;

    assign w_redirect_pc      = redirect_pc_in & ~XLEN'(INSTR_BYTES - 1);
    assign imem_req_valid_out = !rst_in && (r_credits < CW'(DEPTH));
    assign imem_addr_out      = r_fetch_pc;
    assign w_req_fire         = imem_req_valid_out && imem_req_ready_in;
    assign w_flush            = redirect_valid_in;
    assign w_tag_in           = '{pc: r_fetch_pc, epoch: r_epoch};
    assign w_tag_pop          = imem_resp_valid_in && !w_tag_empty;

    // A single epoch bit aliases after two redirects, so tags still in flight
    // at the last redirect are also counted in r_stale and dropped on return.
    assign w_resp_keep = w_tag_pop && (w_tag_out.epoch == r_epoch)
                         && (r_stale == '0) && !w_flush;
    assign w_resp_drop = w_tag_pop && !w_resp_keep;
    assign w_pkt_in    = '{instr: imem_resp_data_in, pc: w_tag_out.pc};

    assign instr_valid_out = !w_buf_empty;
    assign instruction_out = w_pkt_out.instr;
    assign pc_out          = w_pkt_out.pc;
    assign w_pop           = instr_valid_out && instr_ready_in;

    always_comb begin
        w_credits_next = r_credits;
        if (w_req_fire)  w_credits_next = w_credits_next + CW'(1);
        if (w_resp_drop) w_credits_next = w_credits_next - CW'(1);
        // A pop in the flush cycle is already counted in the flushed entries.
        if (w_flush)     w_credits_next = w_credits_next - w_buf_count;
        else if (w_pop)  w_credits_next = w_credits_next - CW'(1);

        w_stale_next = r_stale;
        if (w_flush)
            w_stale_next = w_tag_count + CW'(w_req_fire) - CW'(w_tag_pop);
        else if (w_tag_pop && (r_stale != '0))
            w_stale_next = r_stale - CW'(1);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_fetch_pc <= RESET_PC;
            r_epoch    <= 1'b0;
            r_credits  <= '0;
            r_stale    <= '0;
        end else begin
            if (w_flush) begin
                r_fetch_pc <= w_redirect_pc;
                r_epoch    <= ~r_epoch;
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
            end
            r_credits <= w_credits_next;
            r_stale   <= w_stale_next;
        end
    end

    fifo_sync #(
        .WIDTH ($bits(fetch_tag_t)),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (w_req_fire),
        .i_data  (w_tag_in),
        .i_pop   (w_tag_pop),
        .i_flush (1'b0),
        .o_data  (w_tag_out),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty),
        .o_count (w_tag_count)
    );

    fifo_sync #(
        .WIDTH ($bits(fetch_pkt_t)),
        .DEPTH (DEPTH)
    ) u_instr_buf (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (w_resp_keep),
        .i_data  (w_pkt_in),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_pkt_out),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_count)
    );

    a_resp_has_tag: assert property (@(posedge clk_in) disable iff (rst_in)
        imem_resp_valid_in |-> !w_tag_empty);
    a_tag_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
        w_req_fire |-> !w_tag_full);
    a_buf_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
        w_resp_keep |-> !w_buf_full);
    a_credit_balance: assert property (@(posedge clk_in) disable iff (rst_in)
        r_credits == w_tag_count + w_buf_count);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk_in;
    logic        rst_in;
    logic        redirect_valid_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req_valid_out;
    logic        imem_req_ready_in;
    logic [31:0] imem_addr_out;
    logic        imem_resp_valid_in;
    logic [31:0] imem_resp_data_in;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .redirect_valid_in  (redirect_valid_in),
        .redirect_pc_in     (redirect_pc_in),
        .imem_req_valid_out (imem_req_valid_out),
        .imem_req_ready_in  (imem_req_ready_in),
        .imem_addr_out      (imem_addr_out),
        .imem_resp_valid_in (imem_resp_valid_in),
        .imem_resp_data_in  (imem_resp_data_in),
        .instr_valid_out    (instr_valid_out),
        .instr_ready_in     (instr_ready_in),
        .instruction_out    (instruction_out),
        .pc_out             (pc_out)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_fire = 0;
    int          cyc = 0;
    int          lat = 2;
    int          first_fire_cyc = -1;
    int          first_valid_cyc = -1;
    pend_t       pend[$];
    logic [31:0] exp_req[$];
    logic [31:0] exp_pc[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    // Memory model: fixed latency, in-order, at most one response per cycle.
    initial begin
        imem_resp_valid_in = 1'b0;
        imem_resp_data_in  = '0;
        forever begin
            @(negedge clk_in);
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                imem_resp_valid_in = 1'b1;
                imem_resp_data_in  = word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_resp_valid_in = 1'b0;
                imem_resp_data_in  = '0;
            end
            #4;
            if (!rst_in && imem_req_valid_out && imem_req_ready_in) begin
                n_fire++;
                if (first_fire_cyc < 0) first_fire_cyc = cyc;
                if (exp_req.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL req_unexpected: got %h expected none", imem_addr_out);
                end else begin
                    chk("req_addr", imem_addr_out, exp_req.pop_front());
                end
                pend.push_back('{addr: imem_addr_out, due: cyc + lat});
            end
        end
    end

    // Decode-side monitor: every consumed pair is checked against the scoreboard.
    initial forever begin
        logic [31:0] e;
        @(negedge clk_in);
        #4;
        if (!rst_in && instr_valid_out) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (instr_ready_in) begin
                if (exp_pc.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL instr_unexpected: got pc %h expected none", pc_out);
                end else begin
                    e = exp_pc.pop_front();
                    chk("pc_out", pc_out, e);
                    chk("instruction_out", instruction_out, word(e));
                end
            end
        end
    end

    task automatic drain(input int max);
        int n = 0;
        while ((exp_pc.size() != 0 || pend.size() != 0) && n < max) begin
            @(negedge clk_in);
            n++;
        end
        repeat (2) @(negedge clk_in);
        chk("drain_outstanding", 32'(exp_pc.size() + pend.size()), 32'd0);
        chk("drain_requests", 32'(exp_req.size()), 32'd0);
    endtask

    initial begin
        rst_in            = 1'b1;
        redirect_valid_in = 1'b0;
        redirect_pc_in    = '0;
        imem_req_ready_in = 1'b0;
        instr_ready_in    = 1'b0;

        // Reset values
        repeat (2) @(negedge clk_in);
        chk("rst_req_valid", 32'(imem_req_valid_out), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid_out), 32'd0);
        chk("rst_instruction", instruction_out, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        rst_in = 1'b0;
        #1;
        chk("post_rst_req_valid", 32'(imem_req_valid_out), 32'd1);
        chk("post_rst_addr", imem_addr_out, 32'h0000_0000);

        // Fixed latency 2, decode always ready
        instr_ready_in = 1'b1;
        exp_req = '{32'h0, 32'h4, 32'h8};
        exp_pc  = '{32'h0, 32'h4, 32'h8};
        imem_req_ready_in = 1'b1;
        repeat (3) @(negedge clk_in);
        imem_req_ready_in = 1'b0;
        drain(20);
        chk("first_valid_latency", 32'(first_valid_cyc - first_fire_cyc), 32'd3);

        // Decode stall: credits cap issue at DEPTH
        instr_ready_in = 1'b0;
        n_fire = 0;
        exp_req = '{32'hC, 32'h10, 32'h14, 32'h18};
        exp_pc  = '{32'hC, 32'h10, 32'h14, 32'h18, 32'h1C};
        imem_req_ready_in = 1'b1;
        repeat (8) @(negedge clk_in);
        chk("stall_fires", 32'(n_fire), 32'd4);
        chk("stall_req_valid", 32'(imem_req_valid_out), 32'd0);
        exp_req.push_back(32'h1C);
        instr_ready_in = 1'b1;
        @(negedge clk_in);
        instr_ready_in = 1'b0;
        chk("resume_req_valid", 32'(imem_req_valid_out), 32'd1);
        @(negedge clk_in);
        chk("refull_req_valid", 32'(imem_req_valid_out), 32'd0);
        imem_req_ready_in = 1'b0;
        instr_ready_in    = 1'b1;
        drain(20);

        // Redirect with two requests in flight
        lat = 4;
        exp_req = '{32'h20, 32'h24, 32'h100, 32'h104};
        exp_pc  = '{32'h100, 32'h104};
        imem_req_ready_in = 1'b1;
        repeat (2) @(negedge clk_in);
        imem_req_ready_in = 1'b0;
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 32'h0000_0103;
        @(negedge clk_in);
        redirect_valid_in = 1'b0;
        chk("redirect_addr", imem_addr_out, 32'h0000_0100);
        imem_req_ready_in = 1'b1;
        repeat (2) @(negedge clk_in);
        imem_req_ready_in = 1'b0;
        drain(30);
        lat = 2;

        // Redirect coincident with response, pop and request, then a second
        // redirect whose epoch bit matches the oldest stale tag (0x114).
        instr_ready_in = 1'b0;
        exp_req = '{32'h108, 32'h10C, 32'h110, 32'h114, 32'h200, 32'h300, 32'h304, 32'h308};
        exp_pc  = '{32'h108, 32'h300, 32'h304, 32'h308};
        imem_req_ready_in = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("coinc_valid_before", 32'(instr_valid_out), 32'd1);
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 32'h0000_0200;
        instr_ready_in    = 1'b1;
        @(negedge clk_in);
        chk("coinc_flush_valid", 32'(instr_valid_out), 32'd0);
        chk("coinc_addr", imem_addr_out, 32'h0000_0200);
        redirect_pc_in = 32'h0000_0300;
        @(negedge clk_in);
        redirect_valid_in = 1'b0;
        chk("b2b_addr", imem_addr_out, 32'h0000_0300);
        repeat (3) @(negedge clk_in);
        imem_req_ready_in = 1'b0;
        drain(30);

        // Wrap-around; full issue of DEPTH also shows credits returned to 0
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 32'hFFFF_FFF8;
        @(negedge clk_in);
        redirect_valid_in = 1'b0;
        chk("wrap_addr", imem_addr_out, 32'hFFFF_FFF8);
        instr_ready_in = 1'b0;
        n_fire = 0;
        exp_req = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        exp_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        imem_req_ready_in = 1'b1;
        repeat (6) @(negedge clk_in);
        imem_req_ready_in = 1'b0;
        chk("wrap_fires", 32'(n_fire), 32'd4);
        chk("wrap_req_valid", 32'(imem_req_valid_out), 32'd0);
        instr_ready_in = 1'b1;
        drain(20);

        // Asynchronous reset with three buffered entries
        instr_ready_in = 1'b0;
        exp_req = '{32'h8, 32'hC, 32'h10};
        imem_req_ready_in = 1'b1;
        repeat (3) @(negedge clk_in);
        imem_req_ready_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("prerst_instr_valid", 32'(instr_valid_out), 32'd1);
        #2;
        rst_in = 1'b1;
        pend.delete();
        #1;
        chk("arst_instr_valid", 32'(instr_valid_out), 32'd0);
        chk("arst_req_valid", 32'(imem_req_valid_out), 32'd0);
        chk("arst_pc", pc_out, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        chk("restart_req_valid", 32'(imem_req_valid_out), 32'd1);
        chk("restart_addr", imem_addr_out, 32'h0000_0000);
        exp_req = '{32'h0};
        exp_pc  = '{32'h0};
        instr_ready_in    = 1'b1;
        imem_req_ready_in = 1'b1;
        @(negedge clk_in);
        imem_req_ready_in = 1'b0;
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1);
    end

endmodule
